seven_seg_scanner: RTL and testbench

Time-multiplexing scan controller that drives the seven-segment decoder/anode driver on the four-digit alarm-clock display. It holds a frame-buffered copy of four BCD digits and cycles the selector from left to right at a fixed refresh rate. For each slot it presents the digit value and a per-slot enable. It also applies blanking, leading-zero suppression, blinking for alarm and set modes, and a ghosting guard. It sits between the clock/alarm datapath and the decoder.

---
 rtl/seven_seg_pkg.sv | 27 ++
 rtl/pulse_divider.sv | 41 ++++
 rtl/seven_seg_scanner.sv | 174 +++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan path.
// The selector-to-digit mapping lives here so the decoder side and the
// scanner agree on which nibble belongs to which anode.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;
  localparam int DIGITS_W   = NUM_DIGITS * DIGIT_W;

  // Largest valid BCD code; A..F are treated as "show nothing".
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Digit index of the leftmost anode (selector 0), used for lead-zero logic.
  localparam int LEAD_IDX = NUM_DIGITS - 1;

  // Selector 0 is the leftmost anode, which shows the most significant nibble.
  function automatic logic [SEL_W-1:0] sel_to_digit(input logic [SEL_W-1:0] sel);
    return SEL_W'(NUM_DIGITS - 1) - sel;
  endfunction

  // True when the nibble is a displayable decimal digit.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/pulse_divider.sv
// Free-running modulo-N counter with a terminal-count strobe.
// tc_o is high for the single cycle in which the count sits at N-1; the
// counter wraps to zero on the following edge.
module pulse_divider #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o  = (cnt_q == W'(N - 1));
  assign cnt_o = cnt_q;

  // Next count: wrap at the terminal value, otherwise increment.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (tc_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count must never leave the 0..N-1 range.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= W'(N - 1));

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for the four-digit alarm-clock display.
// Digit data and display modifiers are snapshotted once per frame so a
// mid-frame update can never tear the display; all outputs are decoded from
// registers only.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIV_CNT   = 100000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS_W-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic                  blink_en,
  input  logic                  lz_en,
  input  logic                  disp_en,
  output logic [DIGIT_W-1:0]    num,
  output logic [SEL_W-1:0]      selector,
  output logic                  en,
  output logic                  frame_start
);

  localparam int SLOT_W  = $clog2(DIV_CNT);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  // ---------------------------------------------------------------------
  // Timebases
  // ---------------------------------------------------------------------
  logic [SLOT_W-1:0]  slot_cnt;
  logic               slot_tc;
  logic [BLINK_W-1:0] unused_blink_cnt;
  logic               blink_tc;

  pulse_divider #(
    .N (DIV_CNT),
    .W (SLOT_W)
  ) u_slot_div (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt_o (slot_cnt),
    .tc_o  (slot_tc)
  );

  pulse_divider #(
    .N (BLINK_DIV),
    .W (BLINK_W)
  ) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt_o (unused_blink_cnt),
    .tc_o  (blink_tc)
  );

  // ---------------------------------------------------------------------
  // Scan state and per-frame shadow copies
  // ---------------------------------------------------------------------
  logic [SEL_W-1:0]      sel_q,         sel_d;
  logic                  frame_start_q, frame_start_d;
  logic [DIGITS_W-1:0]   digits_q,      digits_d;
  logic [NUM_DIGITS-1:0] blank_q,       blank_d;
  logic [NUM_DIGITS-1:0] blink_mask_q,  blink_mask_d;
  logic                  blink_en_q,    blink_en_d;
  logic                  lz_en_q,       lz_en_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  disp_en_q,     disp_en_d;

  // The last clock of the rightmost slot closes the frame.
  logic frame_end;
  assign frame_end = slot_tc && (sel_q == SEL_W'(NUM_DIGITS - 1));

  // Next state: advance the selector per slot, snapshot inputs per frame.
  always_comb begin
    sel_d         = sel_q;
    frame_start_d = 1'b0;
    digits_d      = digits_q;
    blank_d       = blank_q;
    blink_mask_d  = blink_mask_q;
    blink_en_d    = blink_en_q;
    lz_en_d       = lz_en_q;
    blink_phase_d = blink_phase_q ^ blink_tc;
    disp_en_d     = disp_en;

    if (slot_tc) begin
      sel_d = sel_q + SEL_W'(1);
    end

    if (frame_end) begin
      frame_start_d = 1'b1;
      digits_d      = digits_in;
      blank_d       = blank_mask;
      blink_mask_d  = blink_mask;
      blink_en_d    = blink_en;
      lz_en_d       = lz_en;
    end
  end

  // State registers; reset clears the display to a dark, all-zero frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q         <= '0;
      frame_start_q <= 1'b0;
      digits_q      <= '0;
      blank_q       <= '0;
      blink_mask_q  <= '0;
      blink_en_q    <= 1'b0;
      lz_en_q       <= 1'b0;
      blink_phase_q <= 1'b0;
      disp_en_q     <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      frame_start_q <= frame_start_d;
      digits_q      <= digits_d;
      blank_q       <= blank_d;
      blink_mask_q  <= blink_mask_d;
      blink_en_q    <= blink_en_d;
      lz_en_q       <= lz_en_d;
      blink_phase_q <= blink_phase_d;
      disp_en_q     <= disp_en_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-digit visibility, computed from the shadow copies only
  // ---------------------------------------------------------------------
  logic [DIGIT_W-1:0]    digit_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_show;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic blink_hidden;
    logic lead_zero;

    assign digit_val[gi]  = digits_q[gi*DIGIT_W +: DIGIT_W];
    assign blink_hidden   = blink_en_q && blink_mask_q[gi] && blink_phase_q;
    assign lead_zero      = lz_en_q && (gi == LEAD_IDX) && (digit_val[gi] == '0);
    assign digit_show[gi] = is_bcd(digit_val[gi]) && !blank_q[gi]
                            && !blink_hidden && !lead_zero;
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  logic [SEL_W-1:0] cur_idx;
  logic             guard_done;

  assign cur_idx     = sel_to_digit(sel_q);
  // Anodes stay dark for the first GUARD clocks of a slot so the previous
  // digit's segments have time to discharge before the new anode turns on.
  assign guard_done  = (slot_cnt >= SLOT_W'(GUARD));

  assign num         = digit_val[cur_idx];
  assign selector    = sel_q;
  assign en          = disp_en_q && guard_done && digit_show[cur_idx];
  assign frame_start = frame_start_q;

  // A frame always begins on the leftmost slot.
  a_frame_start_sel: assert property (@(posedge clk) disable iff (!rst_n)
    frame_start |-> (selector == '0));

  // The frame pulse lasts a single cycle.
  a_frame_start_width: assert property (@(posedge clk) disable iff (!rst_n)
    frame_start |=> !frame_start);

  // An enabled slot never carries an invalid BCD code.
  a_en_valid_bcd: assert property (@(posedge clk) disable iff (!rst_n)
    en |-> is_bcd(num));

  // The guard window keeps the slot dark right after every selector change.
  a_guard_dark: assert property (@(posedge clk) disable iff (!rst_n)
    (slot_cnt == '0) |-> !en);

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with DIV_CNT=8, GUARD=2, BLINK_DIV=64.
// `cyc` counts rising edges since the most recent reset release; outputs are
// sampled on the falling edge, so at sample `cyc` the slot count is cyc%8
// and the selector is (cyc/8)%4.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        blink_en;
  logic        lz_en;
  logic        disp_en;
  logic [3:0]  num;
  logic [1:0]  selector;
  logic        en;
  logic        frame_start;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .DIV_CNT   (8),
    .GUARD     (2),
    .BLINK_DIV (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .blink_en    (blink_en),
    .lz_en       (lz_en),
    .disp_en     (disp_en),
    .num         (num),
    .selector    (selector),
    .en          (en),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Step ncyc clocks, checking every sample against the digits the frame
  // should be showing and a per-slot visibility mask (bit s = slot s lit).
  task automatic run_span(input string tag, input int ncyc,
                          input logic [15:0] exp_digits, input logic [3:0] slot_en);
    int         s;
    int         c;
    logic [3:0] exp_num;
    logic       exp_en;
    logic       exp_fs;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cyc++;
      s       = (cyc / 8) % 4;
      c       = cyc % 8;
      exp_num = exp_digits[(3 - s) * 4 +: 4];
      exp_en  = slot_en[s] && (c >= 2);
      exp_fs  = (s == 0) && (c == 0);
      check({tag, "_sel"}, 32'(selector),    32'(s));
      check({tag, "_num"}, 32'(num),         32'(exp_num));
      check({tag, "_en"},  32'(en),          32'(exp_en));
      check({tag, "_fs"},  32'(frame_start), 32'(exp_fs));
    end
    $display("span %-12s cycles up to %0d checked", tag, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    digits_in  = 16'h1234;
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;
    blink_en   = 1'b0;
    lz_en      = 1'b0;
    disp_en    = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(selector),    32'd0);
    check("rst_num", 32'(num),         32'd0);
    check("rst_en",  32'(en),          32'd0);
    check("rst_fs",  32'(frame_start), 32'd0);
    $display("reset state checked");

    // Release; disp_en is only registered on the first edge.
    rst_n = 1'b1;
    cyc   = 0;
    #1;
    check("release_en", 32'(en), 32'd0);

    // First frame shows the zeroed shadow, then 1234.
    run_span("frame1", 31, 16'h0000, 4'b1111);
    run_span("frame2", 32, 16'h1234, 4'b1111);

    // Tear-free update while selector=1.
    run_span("f3_head", 9, 16'h1234, 4'b1111);
    digits_in = 16'h5678;
    #1;
    check("tear_num_now", 32'(num), 32'h2);
    run_span("f3_tail", 23, 16'h1234, 4'b1111);
    run_span("f4_new", 32, 16'h5678, 4'b1111);

    // Lead-zero, invalid code and mask blanking.
    digits_in  = 16'h0C09;
    lz_en      = 1'b1;
    blank_mask = 4'b0010;
    run_span("blank", 32, 16'h0C09, 4'b1000);

    // Blink on the rightmost digit; phase flips every 64 clocks.
    digits_in  = 16'h1234;
    lz_en      = 1'b0;
    blank_mask = 4'b0000;
    blink_en   = 1'b1;
    blink_mask = 4'b0001;
    run_span("blink_vis_a", 32, 16'h1234, 4'b1111);
    run_span("blink_hid_a", 32, 16'h1234, 4'b0111);
    run_span("blink_hid_b", 32, 16'h1234, 4'b0111);
    run_span("blink_vis_b", 32, 16'h1234, 4'b1111);

    // disp_en drop mid-slot and restore.
    blink_en = 1'b0;
    run_span("pre_disp", 4, 16'h1234, 4'b1111);
    disp_en = 1'b0;
    #1;
    check("disp_off_lag", 32'(en), 32'd1);
    run_span("disp_off", 14, 16'h1234, 4'b0000);
    disp_en = 1'b1;
    #1;
    check("disp_on_lag", 32'(en), 32'd0);
    run_span("disp_on", 14, 16'h1234, 4'b1111);

    // Asynchronous reset at selector=2, no clock edge in between.
    run_span("pre_rst", 20, 16'h1234, 4'b1111);
    rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(selector),    32'd0);
    check("arst_num", 32'(num),         32'd0);
    check("arst_en",  32'(en),          32'd0);
    check("arst_fs",  32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    run_span("restart_f1", 31, 16'h0000, 4'b1111);
    run_span("restart_f2", 8,  16'h1234, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
